// File: rtl/usr_pkg.sv
// Shared encodings for the universal shift register and its command sequencer:
// USR mode select, command opcodes and sequencer FSM states.
package usr_pkg;

  typedef enum logic [1:0] {
    MODE_HOLD = 2'b00,
    MODE_SHR  = 2'b01,
    MODE_SHL  = 2'b10,
    MODE_LOAD = 2'b11
  } usr_mode_e;

  typedef enum logic [1:0] {
    OP_LOAD = 2'b00,
    OP_SHR  = 2'b01,
    OP_SHL  = 2'b10,
    OP_ROTR = 2'b11
  } cmd_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_LOAD  = 2'b01,
    ST_SHIFT = 2'b10,
    ST_DONE  = 2'b11
  } seq_state_e;

endpackage

// File: rtl/universal_shift_register.sv
// WIDTH-bit universal shift register: hold, shift right (msb in), shift left
// (lsb in) or parallel load, selected by the 2-bit mode input.
module universal_shift_register
  import usr_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       s,
  input  logic [WIDTH-1:0] in,
  input  logic             msb,
  input  logic             lsb,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_q <= '0;
    end else begin
      case (usr_mode_e'(s))
        MODE_SHR:  r_q <= {msb, r_q[WIDTH-1:1]};
        MODE_SHL:  r_q <= {r_q[WIDTH-2:0], lsb};
        MODE_LOAD: r_q <= in;
        default:   r_q <= r_q;
      endcase
    end
  end

  assign q = r_q;

endmodule

// File: rtl/usr_command_sequencer.sv
// Command-level controller for the universal shift register: accepts one
// LOAD/SHR/SHL/ROTR command per handshake, steps the USR and captures its result.
module usr_command_sequencer
  import usr_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [CNT_W-1:0] cmd_count,
  input  logic             cmd_fill,
  output logic [1:0]       usr_s,
  output logic [WIDTH-1:0] usr_in,
  output logic             usr_msb,
  output logic             usr_lsb,
  input  logic [WIDTH-1:0] usr_q,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  seq_state_e       r_state;
  seq_state_e       w_next;
  cmd_op_e          r_op;
  logic [WIDTH-1:0] r_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_fill;
  logic [WIDTH-1:0] r_result;
  logic             w_accept;
  usr_mode_e        w_mode;
  logic [WIDTH-1:0] w_usr_in;
  logic             w_msb;
  logic             w_lsb;

  assign w_accept = cmd_valid && (r_state == ST_IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_op     <= OP_LOAD;
      r_data   <= '0;
      r_cnt    <= '0;
      r_fill   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_op   <= cmd_op_e'(cmd_op);
        r_data <= cmd_data;
        r_cnt  <= cmd_count;
        r_fill <= cmd_fill;
      end else if (r_state == ST_SHIFT) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
      if (r_state == ST_DONE) begin
        r_result <= usr_q;
      end
    end
  end

  // Next state and Moore outputs; ROTR feeds usr_q[0] straight back into usr_msb.
  always_comb begin
    w_next   = r_state;
    w_mode   = MODE_HOLD;
    w_usr_in = '0;
    w_msb    = 1'b0;
    w_lsb    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          if (cmd_op_e'(cmd_op) == OP_LOAD) begin
            w_next = ST_LOAD;
          end else if (cmd_count == '0) begin
            w_next = ST_DONE;
          end else begin
            w_next = ST_SHIFT;
          end
        end
      end
      ST_LOAD: begin
        w_mode   = MODE_LOAD;
        w_usr_in = r_data;
        w_next   = ST_DONE;
      end
      ST_SHIFT: begin
        case (r_op)
          OP_SHL: begin
            w_mode = MODE_SHL;
            w_lsb  = r_fill;
          end
          OP_ROTR: begin
            w_mode = MODE_SHR;
            w_msb  = usr_q[0];
          end
          default: begin
            w_mode = MODE_SHR;
            w_msb  = r_fill;
          end
        endcase
        if (r_cnt == CNT_W'(1)) begin
          w_next = ST_DONE;
        end
      end
      ST_DONE: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign cmd_ready = (r_state == ST_IDLE);
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_DONE);
  // The USR holds during DONE, so its output is already the final value there.
  assign result    = (r_state == ST_DONE) ? usr_q : r_result;
  assign usr_s     = w_mode;
  assign usr_in    = w_usr_in;
  assign usr_msb   = w_msb;
  assign usr_lsb   = w_lsb;

endmodule

// File: tb/tb_usr_command_sequencer.sv
// Self-checking bench: sequencer driving a real USR, checked against an
// arithmetic model of each command's effect, latency and mode sequence.
module tb_usr_command_sequencer;

  localparam int WIDTH = 4;
  localparam int CNT_W = 3;

  logic             clk = 1'b0;
  logic             reset;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [CNT_W-1:0] cmd_count;
  logic             cmd_fill;
  logic [1:0]       usr_s;
  logic [WIDTH-1:0] usr_in;
  logic             usr_msb;
  logic             usr_lsb;
  logic [WIDTH-1:0] usr_q;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;

  int n_cmp = 0;
  int n_err = 0;
  int model_q = 0;

  always #10 clk = ~clk;

  usr_command_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_data(cmd_data), .cmd_count(cmd_count), .cmd_fill(cmd_fill),
    .usr_s(usr_s), .usr_in(usr_in), .usr_msb(usr_msb), .usr_lsb(usr_lsb),
    .usr_q(usr_q), .busy(busy), .done(done), .result(result)
  );

  universal_shift_register #(.WIDTH(WIDTH)) usr (
    .clk(clk), .reset(reset), .s(usr_s), .in(usr_in),
    .msb(usr_msb), .lsb(usr_lsb), .q(usr_q)
  );

  // Register value after a command, from plain shift/rotate arithmetic on 4 bits.
  function automatic int model(int q, int op, int data, int cnt, int fill);
    int k, r;
    k = (cnt > 4) ? 4 : cnt;
    case (op)
      0:       return data & 15;
      1:       return ((q >> k) | (fill != 0 ? (((1 << k) - 1) << (4 - k)) : 0)) & 15;
      2:       return ((q << k) | (fill != 0 ? ((1 << k) - 1) : 0)) & 15;
      default: begin
        r = cnt % 4;
        return ((q >> r) | (q << (4 - r))) & 15;
      end
    endcase
  endfunction

  // Issue one command from an IDLE negedge; cmd_valid stays high with junk fields
  // while busy, then drops in the done cycle. Returns at the following negedge.
  task automatic run_cmd(input int op, input int data, input int cnt, input int fill);
    int exp_q, lat, exp_mode, cyc;
    bit seen;
    exp_q    = model(model_q, op, data, cnt, fill);
    lat      = (op == 0) ? 2 : cnt + 1;
    exp_mode = (op == 0) ? 3 : (op == 2) ? 2 : 1;
    n_cmp++;
    if (cmd_ready !== 1'b1) begin
      n_err++;
      $display("FAIL ready_idle: got %b want 1", cmd_ready);
    end
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_data  = 4'(data);
    cmd_count = 3'(cnt);
    cmd_fill  = 1'(fill);
    @(posedge clk);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(negedge clk);
      cyc++;
      n_cmp++;
      if (busy !== 1'b1 || cmd_ready !== 1'b0) begin
        n_err++;
        $display("FAIL busy_cyc%0d op%0d: busy=%b ready=%b want busy=1 ready=0", cyc, op, busy, cmd_ready);
      end
      if (cyc < lat) begin
        n_cmp++;
        if (done !== 1'b0 || usr_s !== 2'(exp_mode)) begin
          n_err++;
          $display("FAIL step_cyc%0d op%0d cnt%0d: done=%b usr_s=%b want done=0 usr_s=%0d",
                   cyc, op, cnt, done, usr_s, exp_mode);
        end
      end else begin
        seen = 1'b1;
        n_cmp++;
        if (done !== 1'b1 || usr_s !== 2'b00 || result !== 4'(exp_q)) begin
          n_err++;
          $display("FAIL done_cyc%0d op%0d cnt%0d: done=%b usr_s=%b result=%h want done=1 usr_s=0 result=%h",
                   cyc, op, cnt, done, usr_s, result, 4'(exp_q));
        end
      end
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = 4'($urandom_range(0, 15));
      cmd_count = 3'($urandom_range(0, 7));
      cmd_fill  = 1'($urandom_range(0, 1));
    end
    cmd_valid = 1'b0;
    if (!seen) begin
      n_err++;
      $display("FAIL timeout op%0d cnt%0d: no done within 20 cycles, want %0d", op, cnt, lat);
    end
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || usr_s !== 2'b00 || result !== 4'(exp_q)) begin
      n_err++;
      $display("FAIL after op%0d: ready=%b busy=%b done=%b usr_s=%b result=%h want 1 0 0 00 %h",
               op, cmd_ready, busy, done, usr_s, result, 4'(exp_q));
    end
    model_q = exp_q;
  endtask

  task automatic test_reset;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 2'b00;
    cmd_data  = '0;
    cmd_count = '0;
    cmd_fill  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || usr_s !== 2'b00 ||
        usr_in !== 4'h0 || usr_msb !== 1'b0 || usr_lsb !== 1'b0 || result !== 4'h0) begin
      n_err++;
      $display("FAIL reset_vals: ready=%b busy=%b done=%b s=%b in=%h msb=%b lsb=%b result=%h want 1 0 0 00 0 0 0 0",
               cmd_ready, busy, done, usr_s, usr_in, usr_msb, usr_lsb, result);
    end
    reset   = 1'b0;
    model_q = 0;
  endtask

  task automatic test_load;
    run_cmd(0, 4'b1010, 0, 0);
    n_cmp++;
    if (result !== 4'b1010) begin
      n_err++;
      $display("FAIL load_1010: result=%b want 1010", result);
    end
  endtask

  task automatic test_shr;
    run_cmd(0, 4'b0000, 0, 0);
    run_cmd(1, 0, 2, 1);
    n_cmp++;
    if (result !== 4'b1100) begin
      n_err++;
      $display("FAIL shr2_fill1: result=%b want 1100", result);
    end
  endtask

  task automatic test_shl;
    run_cmd(0, 4'b1011, 0, 0);
    run_cmd(2, 0, 3, 0);
    n_cmp++;
    if (result !== 4'b1000) begin
      n_err++;
      $display("FAIL shl3_fill0: result=%b want 1000", result);
    end
  endtask

  task automatic test_rotr;
    run_cmd(0, 4'b0011, 0, 0);
    run_cmd(3, 0, 1, 0);
    n_cmp++;
    if (result !== 4'b1001) begin
      n_err++;
      $display("FAIL rotr1: result=%b want 1001", result);
    end
    run_cmd(3, 0, 4, 1);
    n_cmp++;
    if (result !== 4'b1001) begin
      n_err++;
      $display("FAIL rotr4: result=%b want 1001", result);
    end
  endtask

  task automatic test_zero_count;
    run_cmd(0, 4'b0110, 0, 0);
    run_cmd(1, 0, 0, 1);
    n_cmp++;
    if (result !== 4'b0110 || usr_q !== 4'b0110) begin
      n_err++;
      $display("FAIL shr0: result=%b usr_q=%b want 0110 0110", result, usr_q);
    end
  endtask

  task automatic test_reset_mid;
    bit saw_done;
    run_cmd(0, 4'b0101, 0, 0);
    cmd_valid = 1'b1;
    cmd_op    = 2'b10;
    cmd_data  = 4'hF;
    cmd_count = 3'd5;
    cmd_fill  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (usr_s !== 2'b10) begin
      n_err++;
      $display("FAIL mid_shl_cyc1: usr_s=%b want 10", usr_s);
    end
    @(negedge clk);
    reset     = 1'b1;
    cmd_valid = 1'b0;
    #1;
    n_cmp++;
    if (usr_s !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || cmd_ready !== 1'b1 ||
        result !== 4'h0 || usr_q !== 4'h0) begin
      n_err++;
      $display("FAIL mid_reset: s=%b busy=%b done=%b ready=%b result=%h q=%h want 00 0 0 1 0 0",
               usr_s, busy, done, cmd_ready, result, usr_q);
    end
    saw_done = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    reset = 1'b0;
    model_q = 0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0) saw_done = 1'b1;
    end
    n_cmp++;
    if (saw_done) begin
      n_err++;
      $display("FAIL mid_reset_done: done pulsed=1 want 0");
    end
    run_cmd(2, 0, 2, 1);
    run_cmd(0, 4'b1110, 0, 0);
  endtask

  task automatic test_random;
    for (int i = 0; i < 40; i++) begin
      run_cmd($urandom_range(0, 3), $urandom_range(0, 15), $urandom_range(0, 7), $urandom_range(0, 1));
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shr();
    test_shl();
    test_rotr();
    test_zero_count();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
